// File: rtl/ram_bridge_pkg.sv
// Shared constants and FSM encoding for the RAM bus bridge.
package ram_bridge_pkg;

   localparam int WORD_BITS = 32;
   localparam int LANES     = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD    = 3'd1,
      ST_WR    = 3'd2,
      ST_MERGE = 3'd3,
      ST_DONE  = 3'd4
   } bridge_state_t;

endpackage

// File: rtl/ram_bus_bridge_byte_merge.sv
// Byte-lane merge: lanes selected in sel come from new_val, the rest from old_val.
module byte_merge
   import ram_bridge_pkg::*;
(
   input  logic [WORD_BITS-1:0] old_val,
   input  logic [WORD_BITS-1:0] new_val,
   input  logic [LANES-1:0]     sel,
   output logic [WORD_BITS-1:0] merged
);

   always_comb begin
      merged = old_val;
      for (int i = 0; i < LANES; i++) begin
         if (sel[i]) merged[8*i +: 8] = new_val[8*i +: 8];
      end
   end

endmodule

// File: rtl/ram_bus_bridge.sv
// Bridges a simple request/ack word bus onto one port of an external synchronous RAM,
// doing read-modify-write for partial-lane writes.
//
// state | meaning
// IDLE  | waiting for bus_access; captures the request
// RD    | RAM address presented; reads wait one extra cycle for registered ram_dout
// WR    | full-word write strobe
// MERGE | partial write: merged word written back
// DONE  | one-cycle bus_ack
module ram_bus_bridge
   import ram_bridge_pkg::*;
#(
   parameter int addr_bits = 14,
   parameter int data_bits = WORD_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 bus_access,
   input  logic                 bus_wr_en,
   input  logic [29:0]          bus_addr,
   input  logic [LANES-1:0]     bus_bytesel,
   input  logic [data_bits-1:0] bus_wr_val,
   output logic [data_bits-1:0] bus_data,
   output logic                 bus_ack,
   output logic                 bus_error,
   output logic [addr_bits-1:0] ram_addr,
   output logic [data_bits-1:0] ram_din,
   input  logic [data_bits-1:0] ram_dout,
   output logic                 ram_wr_en
);

   bridge_state_t          state_q, state_d;
   logic [addr_bits-1:0]   addr_q, addr_d;
   logic [LANES-1:0]       sel_q, sel_d;
   logic                   wr_q, wr_d;
   logic [data_bits-1:0]   wval_q, wval_d;
   logic [data_bits-1:0]   data_q, data_d;
   logic                   ack_q, ack_d;
   logic                   err_q, err_d;
   logic                   rd_wait_q, rd_wait_d;
   logic                   addr_ok;
   logic [data_bits-1:0]   merged;

   assign addr_ok = (bus_addr >> addr_bits) == 30'd0;

   byte_merge u_merge (
      .old_val (ram_dout),
      .new_val (wval_q),
      .sel     (sel_q),
      .merged  (merged)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      sel_d     = sel_q;
      wr_d      = wr_q;
      wval_d    = wval_q;
      data_d    = data_q;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      rd_wait_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus_access) begin
               if (!addr_ok) begin
                  state_d = ST_DONE;
                  ack_d   = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  addr_d = bus_addr[addr_bits-1:0];
                  sel_d  = bus_bytesel;
                  wr_d   = bus_wr_en;
                  wval_d = bus_wr_val;
                  if (!bus_wr_en)                 state_d = ST_RD;
                  else if (&bus_bytesel)          state_d = ST_WR;
                  else if (bus_bytesel == '0) begin
                     state_d = ST_DONE;
                     ack_d   = 1'b1;
                  end else                        state_d = ST_RD;
               end
            end
         end
         ST_RD: begin
            if (wr_q) begin
               state_d = ST_MERGE;
            end else if (!rd_wait_q) begin
               rd_wait_d = 1'b1;
            end else begin
               state_d = ST_DONE;
               ack_d   = 1'b1;
               data_d  = ram_dout;
            end
         end
         ST_WR, ST_MERGE: begin
            state_d = ST_DONE;
            ack_d   = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         sel_q     <= '0;
         wr_q      <= 1'b0;
         wval_q    <= '0;
         data_q    <= '0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         rd_wait_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         sel_q     <= sel_d;
         wr_q      <= wr_d;
         wval_q    <= wval_d;
         data_q    <= data_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         rd_wait_q <= rd_wait_d;
      end
   end

   assign bus_data  = data_q;
   assign bus_ack   = ack_q;
   assign bus_error = err_q;
   assign ram_addr  = addr_q;
   assign ram_wr_en = (state_q == ST_WR) || (state_q == ST_MERGE);
   // Merge uses ram_dout live: it only becomes valid in the MERGE cycle.
   assign ram_din   = (state_q == ST_MERGE) ? merged : wval_q;

endmodule

// File: tb/tb_ram_bus_bridge.sv
// Randomized bench for ram_bus_bridge against a transaction-level model and a bench-side RAM.
module tb_ram_bus_bridge;

   localparam int AB = 14;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          bus_access = 1'b0;
   logic          bus_wr_en = 1'b0;
   logic [29:0]   bus_addr = '0;
   logic [3:0]    bus_bytesel = '0;
   logic [31:0]   bus_wr_val = '0;
   logic [31:0]   bus_data;
   logic          bus_ack;
   logic          bus_error;
   logic [AB-1:0] ram_addr;
   logic [31:0]   ram_din;
   logic [31:0]   ram_dout = '0;
   logic          ram_wr_en;

   always #5 clk = ~clk;

   ram_bus_bridge #(.addr_bits(AB)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus_access  (bus_access),
      .bus_wr_en   (bus_wr_en),
      .bus_addr    (bus_addr),
      .bus_bytesel (bus_bytesel),
      .bus_wr_val  (bus_wr_val),
      .bus_data    (bus_data),
      .bus_ack     (bus_ack),
      .bus_error   (bus_error),
      .ram_addr    (ram_addr),
      .ram_din     (ram_din),
      .ram_dout    (ram_dout),
      .ram_wr_en   (ram_wr_en)
   );

   // External RAM: registered read, write on strobe; pre_* is a backdoor used only in reset.
   logic [31:0]   mem [0:(1<<AB)-1];
   logic          pre_we = 1'b0;
   logic [AB-1:0] pre_addr = '0;
   logic [31:0]   pre_data = '0;

   always @(posedge clk) begin
      if (pre_we)         mem[pre_addr] <= pre_data;
      else if (ram_wr_en) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc++;

   // Model state: memory image plus per-cycle expectations keyed by absolute cycle.
   logic [31:0] ref_mem [int];
   bit          exp_ack [int];
   bit          exp_err [int];
   bit          exp_we  [int];
   logic [31:0] exp_din [int];
   int          exp_wa  [int];
   logic [31:0] data_upd [int];

   int          n_vec = 0;
   int          n_bad = 0;
   bit          chk_en = 1'b0;
   logic [31:0] cur_data = '0;
   int          last_ack_cyc = -1;
   int          last_we_cyc = -1;
   int          we_cnt = 0;
   logic [31:0] last_din = '0;
   logic        last_err = 1'b0;
   int          t0 = 0;
   bit          ea, ew;

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         cur_data = '0;
      end else begin
         if (bus_ack) begin
            last_ack_cyc = cyc;
            last_err     = bus_error;
         end
         if (ram_wr_en) begin
            last_we_cyc = cyc;
            last_din    = ram_din;
            we_cnt++;
         end
         if (chk_en) begin
            ea = exp_ack.exists(cyc) ? exp_ack[cyc] : 1'b0;
            ew = exp_we.exists(cyc) ? exp_we[cyc] : 1'b0;
            if (data_upd.exists(cyc)) cur_data = data_upd[cyc];
            check("bus_ack", {31'd0, bus_ack}, {31'd0, ea});
            check("ram_wr_en", {31'd0, ram_wr_en}, {31'd0, ew});
            check("bus_data", bus_data, cur_data);
            if (ea) check("bus_error", {31'd0, bus_error}, {31'd0, exp_err[cyc]});
            if (ew) begin
               check("ram_din", ram_din, exp_din[cyc]);
               check("ram_addr", {18'd0, ram_addr}, exp_wa[cyc]);
            end
         end
      end
   end

   task automatic preload(input int a, input logic [31:0] d);
      pre_we   = 1'b1;
      pre_addr = a[AB-1:0];
      pre_data = d;
      ref_mem[a] = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   // Starts in an IDLE cycle (cycle 0) and returns at the negedge of the IDLE cycle after ack.
   task automatic txn(input logic wr, input logic [29:0] addr, input logic [3:0] sel,
                      input logic [31:0] val, input bit hold);
      int lat, wk, a;
      logic err;
      logic [31:0] m, nw;
      t0 = cyc;
      bus_access  = 1'b1;
      bus_wr_en   = wr;
      bus_addr    = addr;
      bus_bytesel = sel;
      bus_wr_val  = val;
      a   = int'(addr);
      err = addr >= 30'(1 << AB);
      wk  = 0;
      if (err) lat = 1;
      else if (!wr) begin
         lat = 3;
         data_upd[t0 + 3] = ref_mem[a];
      end else if (sel == 4'hF) begin
         lat = 2;
         wk  = 1;
         nw  = val;
      end else if (sel == 4'h0) lat = 1;
      else begin
         lat = 3;
         wk  = 2;
         m   = '0;
         for (int i = 0; i < 4; i++) if (sel[i]) m = m | (32'hFF << (8 * i));
         nw  = (ref_mem[a] & ~m) | (val & m);
      end
      exp_ack[t0 + lat] = 1'b1;
      exp_err[t0 + lat] = err;
      if (wk != 0) begin
         exp_we[t0 + wk]  = 1'b1;
         exp_din[t0 + wk] = nw;
         exp_wa[t0 + wk]  = a;
         ref_mem[a]       = nw;
      end
      for (int k = 1; k <= lat + 1; k++) begin
         @(negedge clk);
         if (k == lat && !hold) bus_access = 1'b0;
      end
   endtask

   int w0, a1, g;
   logic [29:0] ra;
   logic [3:0]  rs;

   initial begin
      repeat (2) @(negedge clk);
      for (int i = 0; i < 64; i++) preload(i, $urandom);
      for (int i = (1 << AB) - 4; i < (1 << AB); i++) preload(i, $urandom);
      preload('h10, 32'hDEADBEEF);
      preload('h20, 32'h11223344);
      check("rst bus_ack", {31'd0, bus_ack}, 32'd0);
      check("rst bus_error", {31'd0, bus_error}, 32'd0);
      check("rst ram_wr_en", {31'd0, ram_wr_en}, 32'd0);
      check("rst bus_data", bus_data, 32'd0);
      check("rst ram_din", ram_din, 32'd0);
      check("rst ram_addr", {18'd0, ram_addr}, 32'd0);
      rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);

      w0 = we_cnt;
      txn(1'b0, 30'h10, 4'h3, 32'h0, 1'b0);
      check("read latency", last_ack_cyc - t0, 3);
      check("read data", bus_data, 32'hDEADBEEF);
      check("read error", {31'd0, last_err}, 32'd0);
      check("read strobes", we_cnt - w0, 0);

      txn(1'b1, 30'h20, 4'b0101, 32'hAABBCCDD, 1'b0);
      check("partial we cycle", last_we_cyc - t0, 2);
      check("partial din", last_din, 32'h11BB33DD);
      check("partial latency", last_ack_cyc - t0, 3);
      txn(1'b0, 30'h20, 4'h0, 32'h0, 1'b0);
      check("partial readback", bus_data, 32'h11BB33DD);

      txn(1'b1, 30'h3, 4'hF, 32'hCAFEF00D, 1'b0);
      check("full we cycle", last_we_cyc - t0, 1);
      check("full latency", last_ack_cyc - t0, 2);
      txn(1'b0, 30'h3, 4'h1, 32'h0, 1'b0);
      check("full readback", bus_data, 32'hCAFEF00D);

      w0 = we_cnt;
      txn(1'b0, 30'h4000, 4'hF, 32'h0, 1'b0);
      check("error latency", last_ack_cyc - t0, 1);
      check("error flag", {31'd0, last_err}, 32'd1);
      check("error data held", bus_data, 32'hCAFEF00D);
      txn(1'b1, 30'h5, 4'h0, 32'h12345678, 1'b0);
      check("noop latency", last_ack_cyc - t0, 1);
      check("err/noop strobes", we_cnt - w0, 0);

      w0 = we_cnt;
      bus_access  = 1'b1;
      bus_wr_en   = 1'b1;
      bus_addr    = 30'h20;
      bus_bytesel = 4'b0101;
      bus_wr_val  = 32'h55667788;
      @(negedge clk);
      #1 rst = 1'b1;
      bus_access = 1'b0;
      @(negedge clk);
      check("mid rst bus_ack", {31'd0, bus_ack}, 32'd0);
      check("mid rst bus_error", {31'd0, bus_error}, 32'd0);
      check("mid rst ram_wr_en", {31'd0, ram_wr_en}, 32'd0);
      check("mid rst bus_data", bus_data, 32'd0);
      check("mid rst ram_din", ram_din, 32'd0);
      check("mid rst ram_addr", {18'd0, ram_addr}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("aborted write strobes", we_cnt - w0, 0);
      txn(1'b0, 30'h20, 4'h0, 32'h0, 1'b0);
      check("aborted write ram", bus_data, 32'h11BB33DD);

      txn(1'b0, 30'h10, 4'hF, 32'h0, 1'b1);
      a1 = last_ack_cyc;
      txn(1'b0, 30'h3, 4'hF, 32'h0, 1'b0);
      check("b2b ack spacing", last_ack_cyc - a1, 4);
      check("b2b second data", bus_data, 32'hCAFEF00D);

      for (int n = 0; n < 80; n++) begin
         case ($urandom_range(0, 9))
            0:       ra = 30'h4000 + 30'($urandom_range(0, 4095)) + (30'($urandom_range(0, 1)) << 20);
            1:       ra = 30'((1 << AB) - 4 + $urandom_range(0, 3));
            default: ra = 30'($urandom_range(0, 63));
         endcase
         case ($urandom_range(0, 4))
            0:       rs = 4'h0;
            1:       rs = 4'hF;
            default: rs = 4'($urandom_range(0, 15));
         endcase
         txn(1'($urandom_range(0, 1)), ra, rs, $urandom, 1'b0);
         g = $urandom_range(0, 2);
         repeat (g) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/ram_bus_bridge.md
RAM_BUS_BRIDGE -- requirements
Module: ram_bus_bridge

Interface
REQ-001 SHALL have parameter addr_bits, default 14: RAM word-address width; RAM depth is 2**addr_bits words.
REQ-002 SHALL have parameter data_bits, fixed at 32: RAM word width; other values unsupported.
REQ-003 SHALL use one clock and an asynchronous, active-high reset, with ports named as below.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 bus_access  input  1  request valid; held by the master until bus_ack.
REQ-007 bus_wr_en  input  1  1 = write, 0 = read.
REQ-008 bus_addr  input  30  word address (byte address bits 31:2).
REQ-009 bus_bytesel  input  4  byte-lane enables; bit n selects data bits 8n+7:8n.
REQ-010 bus_wr_val  input  32  write data.
REQ-011 bus_data  output  32  read data.
REQ-012 bus_ack  output  1  one-cycle completion strobe.
REQ-013 bus_error  output  1  address out of range; valid only with bus_ack.
REQ-014 ram_addr  output  addr_bits  RAM port address.
REQ-015 ram_din  output  32  RAM write data.
REQ-016 ram_dout  input  32  RAM read data, registered inside the RAM, valid one cycle after ram_addr is presented.
REQ-017 ram_wr_en  output  1  RAM write strobe.

Function
REQ-018 SHALL implement FSM states IDLE, RD, WR, MERGE, DONE; bus_access is sampled only in IDLE.
REQ-019 Cycle numbering: cycle 0 is the IDLE cycle with bus_access=1. At the end of cycle 0 the FSM SHALL capture addr, bytesel, wr_en and wr_val.
REQ-020 Range check: if bus_addr[29:addr_bits] != 0, the next state SHALL be DONE with bus_error=1, and no RAM access occurs.
REQ-021 Read, or write with bytesel not 4'b1111 and not 0: next state SHALL be RD. In RD, ram_addr = captured address and ram_wr_en = 0.
REQ-022 Read from RD: next state SHALL be DONE. At that edge, bus_data SHALL register ram_dout and bus_ack SHALL register 1; bus_ack is high in cycle 3.
REQ-023 Partial write from RD: next state SHALL be MERGE. In MERGE (cycle 2):
- ram_din = ram_dout with the selected lanes replaced by wr_val lanes;
- ram_wr_en = 1 for exactly this cycle;
- bus_ack is high in cycle 3.
REQ-024 Full-word write (bytesel 4'b1111): next state SHALL be WR (cycle 1) with ram_din = wr_val and ram_wr_en = 1; bus_ack is high in cycle 2.
REQ-025 Write with bytesel 4'b0000: SHALL be a no-op going straight to DONE; ram_wr_en is never asserted and bus_ack is high in cycle 1.
REQ-026 DONE SHALL last one cycle with bus_ack=1, ignore bus_access, then return to IDLE. Back-to-back requests therefore have at least one IDLE cycle between them.
REQ-027 bus_data SHALL hold its value until the next read completes. It is not updated by writes or errors.
REQ-028 bus_access deasserting mid-transaction SHALL NOT abort the transaction.
REQ-029 Read byte lanes SHALL be returned in full regardless of bytesel.
REQ-030 bus_ack, bus_error and ram_wr_en SHALL be registered or decoded from state only, with no combinational path from bus inputs.

Reset
REQ-031 rst SHALL asynchronously force the following values:
- state IDLE;
- bus_ack, bus_error and ram_wr_en to 0;
- bus_data, ram_din and ram_addr to 0.
REQ-032 If rst asserts before the ram_wr_en edge of a write, that write SHALL NOT occur. After rst deasserts, the first request is accepted from IDLE normally.

Structure
REQ-033 State encoding, lane count (4) and the word-width constant SHALL live in shared package ram_bridge_pkg.
REQ-034 Lane merging SHALL be a combinational sub-module byte_merge, with inputs old, new and sel and output merged.
REQ-035 The RAM SHALL be external; the bridge drives one dual-port RAM port.

Verification
REQ-036 Read: RAM[0x10]=0xDEADBEEF; read addr 0x10 -> bus_ack in cycle 3, bus_data=0xDEADBEEF, bus_error=0, ram_wr_en never 1.
REQ-037 Partial write: RAM[0x20]=0x11223344; write 0xAABBCCDD with bytesel 4'b0101 -> ram_wr_en only in cycle 2, ram_din=0x11BB33DD, bus_ack in cycle 3. A following read returns 0x11BB33DD.
REQ-038 Full write: 0xCAFEF00D to 0x3 with bytesel 4'b1111 -> ram_wr_en in cycle 1, bus_ack in cycle 2. A following read returns 0xCAFEF00D.
REQ-039 Error and no-op: read addr 0x4000 with addr_bits=14 -> bus_ack and bus_error in cycle 1, no RAM strobe, bus_data unchanged. Write with bytesel 0 -> ack in cycle 1, no RAM strobe.
REQ-040 Reset and back-to-back: rst pulsed in cycle 1 of a partial write -> RAM unchanged and outputs 0. With bus_access held high through two reads, bus_ack pulses are separated by one IDLE cycle and each lasts one cycle.
